// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the single ROB writeback port among NREQ result sources.
// Each source owns a one-entry slot; the granted slot drains into a registered writeback stage.
module wb_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rob_flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_error,
    input  logic [5*NREQ-1:0]    req_ecause,
    input  logic [7*NREQ-1:0]    req_robid,
    input  logic [32*NREQ-1:0]   req_result,
    output logic                 wb_valid,
    output logic                 wb_error,
    output logic [4:0]           wb_ecause,
    output logic [6:0]           wb_robid,
    output logic [31:0]          wb_result
);

    logic [NREQ-1:0]        slot_valid;
    logic [NREQ-1:0]        slot_valid_next;
    logic [NREQ-1:0]        slot_error;
    logic [NREQ-1:0][4:0]   slot_ecause;
    logic [NREQ-1:0][6:0]   slot_robid;
    logic [NREQ-1:0][31:0]  slot_result;

    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          rr_ptr_next;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        accept;
    logic                   gnt_any;
    logic [PW-1:0]          gnt_idx;
    logic [PW-1:0]          scan_idx;

    // First valid slot at or after rr_ptr wins; depends on registered state only.
    always_comb begin
        grant    = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = PW'((32'(rr_ptr) + k) % NREQ);
            if (!gnt_any && slot_valid[scan_idx]) begin
                gnt_any         = 1'b1;
                gnt_idx         = scan_idx;
                grant[scan_idx] = 1'b1;
            end
        end
    end

    // A slot being drained this cycle can take a new beat, so a granted source streams at full rate.
    assign req_ready = ~slot_valid | grant;
    assign accept    = req_valid & req_ready & {NREQ{~rob_flush}};

    always_comb begin
        slot_valid_next = (slot_valid & ~grant) | accept;
        rr_ptr_next     = rr_ptr;
        if (rob_flush) begin
            slot_valid_next = '0;
        end else if (gnt_any) begin
            rr_ptr_next = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
            rr_ptr     <= '0;
        end else begin
            slot_valid <= slot_valid_next;
            rr_ptr     <= rr_ptr_next;
        end
    end

    // Slot payloads need no reset: slot_valid qualifies them.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                slot_error[i]  <= req_error[i];
                slot_ecause[i] <= req_ecause[5*i +: 5];
                slot_robid[i]  <= req_robid[7*i +: 7];
                slot_result[i] <= req_result[32*i +: 32];
            end
        end
    end

    // Writeback stage: data fields hold when nothing is granted or on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_error  <= 1'b0;
            wb_ecause <= '0;
            wb_robid  <= '0;
            wb_result <= '0;
        end else if (!rob_flush && gnt_any) begin
            wb_valid  <= 1'b1;
            wb_error  <= slot_error[gnt_idx];
            wb_ecause <= slot_ecause[gnt_idx];
            wb_robid  <= slot_robid[gnt_idx];
            wb_result <= slot_result[gnt_idx];
        end else begin
            wb_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, checked by a slot-level
// reference model feeding a scoreboard queue that a separate monitor drains.
module tb_wb_arbiter;

    localparam int NREQ = 4;
    localparam int PW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rob_flush;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_error;
    logic [5*NREQ-1:0]    req_ecause;
    logic [7*NREQ-1:0]    req_robid;
    logic [32*NREQ-1:0]   req_result;
    logic                 wb_valid;
    logic                 wb_error;
    logic [4:0]           wb_ecause;
    logic [6:0]           wb_robid;
    logic [31:0]          wb_result;

    wb_arbiter #(.NREQ(NREQ), .PW(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rob_flush  (rob_flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_error  (req_error),
        .req_ecause (req_ecause),
        .req_robid  (req_robid),
        .req_result (req_result),
        .wb_valid   (wb_valid),
        .wb_error   (wb_error),
        .wb_ecause  (wb_ecause),
        .wb_robid   (wb_robid),
        .wb_result  (wb_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        err;
        logic [4:0]  ec;
        logic [6:0]  rid;
        logic [31:0] res;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Reference model: one buffered beat per source, rotating priority pointer.
    logic        m_valid [NREQ];
    logic        m_err   [NREQ];
    logic [4:0]  m_ec    [NREQ];
    logic [6:0]  m_rid   [NREQ];
    logic [31:0] m_res   [NREQ];
    int          m_ptr;
    int          m_win;
    logic [NREQ-1:0] m_ready;
    exp_t        m_item;

    initial begin
        for (int i = 0; i < NREQ; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            m_win = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (m_win < 0 && m_valid[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
            end
            for (int i = 0; i < NREQ; i++) m_ready[i] = !m_valid[i] || (m_win == i);
            check("req_ready", 32'(req_ready), 32'(m_ready));
            if (rst) begin
                for (int i = 0; i < NREQ; i++) m_valid[i] = 1'b0;
                m_ptr = 0;
            end else if (rob_flush) begin
                for (int i = 0; i < NREQ; i++) m_valid[i] = 1'b0;
            end else begin
                if (m_win >= 0) begin
                    m_item.cyc = cyc + 1;
                    m_item.err = m_err[m_win];
                    m_item.ec  = m_ec[m_win];
                    m_item.rid = m_rid[m_win];
                    m_item.res = m_res[m_win];
                    q.push_back(m_item);
                    m_valid[m_win] = 1'b0;
                    m_ptr = (m_win + 1) % NREQ;
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && m_ready[i]) begin
                        m_valid[i] = 1'b1;
                        m_err[i]   = req_error[i];
                        m_ec[i]    = req_ecause[5*i +: 5];
                        m_rid[i]   = req_robid[7*i +: 7];
                        m_res[i]   = req_result[32*i +: 32];
                    end
                end
            end
        end
    end

    // Monitor: every wb_valid must match the oldest expectation due this cycle.
    exp_t last = '{cyc: 0, err: 1'b0, ec: 5'd0, rid: 7'd0, res: 32'd0};
    exp_t got;
    logic due;

    always @(negedge clk) begin
        if (cyc > 0) begin
            due = (q.size() > 0) && (q[0].cyc == cyc);
            if (wb_valid === 1'b1) begin
                if (!due) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wb_spurious cyc=%0d actual robid=%0d required no writeback", cyc, wb_robid);
                end else begin
                    got = q.pop_front();
                    check("wb_robid",  32'(wb_robid),  32'(got.rid));
                    check("wb_result", wb_result,      got.res);
                    check("wb_error",  32'(wb_error),  32'(got.err));
                    check("wb_ecause", 32'(wb_ecause), 32'(got.ec));
                    last = got;
                end
            end else begin
                check("wb_valid", 32'(wb_valid), 32'(due));
                if (due) void'(q.pop_front());
                check("wb_robid_hold",  32'(wb_robid),  32'(last.rid));
                check("wb_result_hold", wb_result,      last.res);
                check("wb_error_hold",  32'(wb_error),  32'(last.err));
                check("wb_ecause_hold", 32'(wb_ecause), 32'(last.ec));
            end
            if (rst) last = '{cyc: 0, err: 1'b0, ec: 5'd0, rid: 7'd0, res: 32'd0};
        end
    end

    logic [NREQ-1:0] took;

    task automatic tick();
        @(negedge clk);
        took = req_valid & req_ready & {NREQ{~rob_flush}};
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [6:0] rid, input logic [31:0] res,
                            input logic err, input logic [4:0] ec);
        req_robid[7*p +: 7]    = rid;
        req_result[32*p +: 32] = res;
        req_error[p]           = err;
        req_ecause[5*p +: 5]   = ec;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    int rid1, rid3;

    initial begin
        rst = 1'b1; rob_flush = 1'b0; req_valid = '0; req_error = '0;
        req_ecause = '0; req_robid = '0; req_result = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single result
        set_port(0, 7'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        req_valid = 4'b0001; tick();
        req_valid = '0; repeat (4) tick();

        // All-port collision
        for (int p = 0; p < NREQ; p++) set_port(p, 7'(10 + p), 32'(32'h1000 + p), 1'b0, 5'd0);
        req_valid = 4'b1111; tick();
        req_valid = '0; repeat (6) tick();

        // Streaming on port 2
        for (int k = 0; k < 3; k++) begin
            set_port(2, 7'(20 + k), 32'(32'h2000 + k), 1'b0, 5'd0);
            req_valid = 4'b0100; tick();
        end
        req_valid = '0; repeat (4) tick();

        // Contention between ports 1 and 3
        rid1 = 40; rid3 = 60;
        req_valid = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            set_port(1, 7'(rid1), 32'(32'h4000 + rid1), 1'b0, 5'd0);
            set_port(3, 7'(rid3), 32'(32'h6000 + rid3), 1'b0, 5'd0);
            tick();
            if (took[1]) rid1++;
            if (took[3]) rid3++;
        end
        req_valid = '0; repeat (4) tick();

        // Flush with full slots and a pending writeback
        set_port(3, 7'd50, 32'h5050, 1'b0, 5'd0);
        req_valid = 4'b1000; tick();
        set_port(0, 7'd51, 32'h5151, 1'b0, 5'd0);
        set_port(1, 7'd52, 32'h5252, 1'b0, 5'd0);
        req_valid = 4'b0011; tick();
        set_port(2, 7'd30, 32'h3030, 1'b0, 5'd0);
        req_valid = 4'b0100; rob_flush = 1'b1; tick();
        req_valid = '0; rob_flush = 1'b0; repeat (4) tick();

        // Error propagation, then reset mid-stream
        set_port(3, 7'd70, 32'h7070, 1'b1, 5'd7);
        req_valid = 4'b1000; tick();
        req_valid = '0; repeat (3) tick();
        for (int p = 0; p < NREQ; p++) set_port(p, 7'(80 + p), 32'(32'h8000 + p), 1'b0, 5'd0);
        req_valid = 4'b1111; tick();
        req_valid = '0; tick(); tick();
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        for (int p = 0; p < NREQ; p++) set_port(p, 7'(90 + p), 32'(32'h9000 + p), 1'b0, 5'd0);
        req_valid = 4'b1111; tick();
        req_valid = '0; repeat (6) tick();

        // Random traffic with occasional flush and reset
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < NREQ; p++)
                set_port(p, 7'($urandom), $urandom, 1'($urandom_range(0, 7) == 0), 5'($urandom));
            req_valid = NREQ'($urandom);
            rob_flush = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0; rob_flush = 1'b0; req_valid = '0;
        repeat (8) tick();

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
